// File: rtl/sysref_pkg.sv
// Shared types and constants for the programmable SYSREF generator.
// Mode and state encodings are shared with anything that decodes the debug state.
package sysref_pkg;

  localparam int DEFAULT_HALF_P = 24;

  typedef enum logic [1:0] {
    SYSREF_OFF   = 2'd0,
    SYSREF_CONT  = 2'd1,
    SYSREF_BURST = 2'd2,
    SYSREF_RSVD  = 2'd3
  } sysref_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_DRAIN = 2'd3
  } sysref_state_e;

  // The reserved encoding behaves exactly like OFF.
  function automatic logic mode_is_off(input logic [1:0] m);
    return (m == SYSREF_OFF) || (m == SYSREF_RSVD);
  endfunction

endpackage

// File: rtl/sysref_phase_ctr.sv
// Phase counter for one SYSREF half-period: counts 0..H-1, flags terminal count.
// H is captured on load so a changing input never stretches the phase in flight.
module sysref_phase_ctr
  import sysref_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 restart,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] h_in,
  output logic                 tc
);

  logic [DIV_WIDTH-1:0] count;
  logic [DIV_WIDTH-1:0] h_q;

  assign tc = en && (count == (h_q - DIV_WIDTH'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      h_q   <= '0;
    end else begin
      if (load) h_q <= h_in;
      if (restart) begin
        count <= '0;
      end else if (en) begin
        count <= tc ? '0 : count + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/sysref_gen.sv
// Programmable SYSREF generator: off / continuous / burst, runt-free stop, realign strobe.
// Handshake-free block: every control input is sampled on each rising aclk edge, no valid/ready.
module sysref_gen
  import sysref_pkg::*;
#(
  parameter int DIV_WIDTH    = 8,
  parameter int BURST_WIDTH  = 8,
  parameter int DEFAULT_HALF = DEFAULT_HALF_P
) (
  input  logic                   aclk,
  input  logic                   aclk_rst,
  input  logic [1:0]             mode_i,
  input  logic [DIV_WIDTH-1:0]   half_period_i,
  input  logic [BURST_WIDTH-1:0] burst_count_i,
  input  logic                   start_i,
  input  logic                   align_i,
  output logic                   sysref_o,
  output logic                   edge_o,
  output logic                   busy_o,
  output sysref_state_e          dbg_state
);

  // Reset asserts immediately but releases two clean aclk edges later.
  logic [1:0] rst_pipe;
  logic       rst_int;

  always_ff @(posedge aclk or posedge aclk_rst) begin
    if (aclk_rst) rst_pipe <= 2'b11;
    else          rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_int = rst_pipe[1];

  sysref_state_e          state, state_n;
  logic                   sysref_n, edge_n;
  logic [BURST_WIDTH-1:0] rem, rem_n;
  logic                   restart, load, tc, stop;
  logic [DIV_WIDTH-1:0]   h_eff;
  sysref_mode_e           mode_e;

  assign mode_e = sysref_mode_e'(mode_i);
  assign h_eff  = (half_period_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(DEFAULT_HALF) : half_period_i;

  sysref_phase_ctr #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_phase (
    .clk    (aclk),
    .rst    (rst_int),
    .en     (state != ST_IDLE),
    .restart(restart),
    .load   (load),
    .h_in   (h_eff),
    .tc     (tc)
  );

  always_ff @(posedge aclk or posedge rst_int) begin
    if (rst_int) begin
      state    <= ST_IDLE;
      sysref_o <= 1'b0;
      edge_o   <= 1'b0;
      rem      <= '0;
    end else begin
      state    <= state_n;
      sysref_o <= sysref_n;
      edge_o   <= edge_n;
      rem      <= rem_n;
    end
  end

  always_comb begin
    state_n  = state;
    sysref_n = sysref_o;
    edge_n   = 1'b0;
    rem_n    = rem;
    restart  = 1'b0;
    load     = 1'b0;
    stop     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (mode_e == SYSREF_CONT) begin
          state_n  = ST_RUN;
          sysref_n = 1'b1;
          edge_n   = 1'b1;
          restart  = 1'b1;
          load     = 1'b1;
        end else if (mode_e == SYSREF_BURST && start_i && burst_count_i != '0) begin
          state_n  = ST_BURST;
          rem_n    = burst_count_i;
          sysref_n = 1'b1;
          edge_n   = 1'b1;
          restart  = 1'b1;
          load     = 1'b1;
        end
      end

      ST_RUN: begin
        // A mode change outranks a simultaneous align strobe.
        if (mode_e != SYSREF_CONT) begin
          stop = 1'b1;
        end else if (align_i) begin
          sysref_n = 1'b0;
          restart  = 1'b1;
        end else if (tc) begin
          sysref_n = !sysref_o;
          edge_n   = !sysref_o;
          load     = !sysref_o;
        end
      end

      ST_BURST: begin
        if (mode_is_off(mode_i)) begin
          stop = 1'b1;
        end else if (tc) begin
          if (sysref_o) begin
            sysref_n = 1'b0;
            // The final pulse ends the burst at its falling edge; no trailing low phase.
            if (rem <= BURST_WIDTH'(1)) begin
              rem_n   = '0;
              state_n = ST_IDLE;
            end else begin
              rem_n = rem - BURST_WIDTH'(1);
            end
          end else begin
            sysref_n = 1'b1;
            edge_n   = 1'b1;
            load     = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (tc) begin
          sysref_n = 1'b0;
          state_n  = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase

    // Stopping never cuts a high phase short: finish it in DRAIN unless it ends now.
    if (stop) begin
      rem_n = '0;
      if (!sysref_o || tc) begin
        sysref_n = 1'b0;
        state_n  = ST_IDLE;
      end else begin
        state_n = ST_DRAIN;
      end
    end

    if (state != ST_IDLE && state_n == ST_IDLE) restart = 1'b1;
  end

  assign busy_o    = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_sysref_gen.sv
// Directed bench for sysref_gen: timeline model of the SYSREF waveform plus literal checks.
module tb_sysref_gen;
  import sysref_pkg::*;

  logic          aclk = 1'b0;
  logic          aclk_rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [7:0]    half = 8'd24;
  logic [7:0]    bc = 8'd0;
  logic          start = 1'b0;
  logic          align = 1'b0;
  logic          sysref_o, edge_o, busy_o;
  sysref_state_e dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  sysref_gen #(.DIV_WIDTH(8), .BURST_WIDTH(8), .DEFAULT_HALF(24)) dut (
    .aclk         (aclk),
    .aclk_rst     (aclk_rst),
    .mode_i       (mode),
    .half_period_i(half),
    .burst_count_i(bc),
    .start_i      (start),
    .align_i      (align),
    .sysref_o     (sysref_o),
    .edge_o       (edge_o),
    .busy_o       (busy_o),
    .dbg_state    (dbg_state)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  // The waveform is described by the cycle of the latest rise (m_t0) and the latched
  // half-period: high over [t0, t0+h), low over [t0+h, t0+2h), next rise at t0+2h.
  int   cyc = 0;
  int   hold = 0;
  bit   m_active = 0, m_sys = 0, m_edge = 0, m_drain = 0, m_burst = 0;
  int   m_h = 0, m_t0 = 0, m_left = 0;
  int   edge_t[$];
  int   hi_cnt = 0;
  logic [15:0] exp_q[$];

  function automatic int heff();
    return (half < 8'd2) ? 24 : int'(half);
  endfunction

  task automatic model_step();
    int pos;
    bit stop;
    m_edge = 0;
    if (!m_active) begin
      m_sys = 0;
      if (mode == 2'd1 || (mode == 2'd2 && start && bc != 8'd0)) begin
        m_active = 1; m_burst = (mode == 2'd2); m_left = int'(bc);
        m_h = heff(); m_t0 = cyc; m_drain = 0; m_sys = 1; m_edge = 1;
      end
    end else begin
      stop = !m_drain && (m_burst ? (mode == 2'd0 || mode == 2'd3) : (mode != 2'd1));
      if (stop && !m_sys) begin
        m_active = 0;
      end else begin
        if (stop) m_drain = 1;
        if (!m_drain && !m_burst && align) m_t0 = cyc - m_h;
        pos = cyc - m_t0;
        if (pos == 2 * m_h) begin
          m_t0 = cyc; m_h = heff(); m_sys = 1; m_edge = 1;
        end else if (pos == m_h) begin
          m_sys = 0;
          if (m_drain) m_active = 0;
          else if (m_burst) begin
            m_left--;
            if (m_left == 0) m_active = 0;
          end
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(posedge aclk) begin
    cyc++;
    if (aclk_rst) begin
      m_active = 0; m_sys = 0; m_edge = 0; m_drain = 0; hold = 2;
    end else if (hold > 0) begin
      hold--;
    end else begin
      model_step();
    end
    #1;
    check("sysref", int'(sysref_o), int'(m_sys));
    check("edge", int'(edge_o), int'(m_edge));
    check("busy", int'(busy_o), int'(m_active));
    if (edge_o) edge_t.push_back(cyc);
    if (sysref_o) hi_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic clear_log();
    edge_t.delete();
    hi_cnt = 0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200 && m_active; i++) @(negedge aclk);
    check({nm, " idle timeout"}, int'(m_active), 0);
    cycles(2);
  endtask

  // Measured edge spacing against the literal gaps queued in exp_q.
  task automatic check_gaps(input string nm);
    check({nm, " edge count"}, edge_t.size(), exp_q.size() + 1);
    for (int i = 1; i < edge_t.size() && exp_q.size() > 0; i++)
      check({nm, " gap"}, edge_t[i] - edge_t[i-1], int'(exp_q.pop_front()));
    exp_q.delete();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    cycles(3);
    check("reset sysref", int'(sysref_o), 0);
    check("reset edge", int'(edge_o), 0);
    check("reset busy", int'(busy_o), 0);
    check("reset state", int'(dbg_state), int'(ST_IDLE));
    aclk_rst = 1'b0;
    cycles(4);

    // Continuous H=24: rise the edge after mode is sampled, period 48.
    clear_log();
    half = 8'd24; mode = 2'd1;
    @(posedge aclk); #2;
    check("cont first rise", int'(sysref_o), 1);
    check("cont first edge", int'(edge_o), 1);
    cycles(120);
    mode = 2'd0;
    wait_idle("cont");
    exp_q.push_back(16'd48); exp_q.push_back(16'd48);
    check_gaps("cont");
    check("cont duty", hi_cnt, 72);

    // Clamp of 0 and 1 to 24, then 24->10 change inside a high phase.
    clear_log();
    half = 8'd0; mode = 2'd1;
    cycles(5);  half = 8'd1;
    cycles(48); half = 8'd10;
    cycles(73); mode = 2'd0;
    wait_idle("clamp");
    exp_q.push_back(16'd48); exp_q.push_back(16'd48); exp_q.push_back(16'd20);
    check_gaps("clamp");

    // Burst of 3 at H=4, second start and an align mid-burst are ignored.
    clear_log();
    half = 8'd4; bc = 8'd3; mode = 2'd2; start = 1'b1;
    cycles(1); start = 1'b0;
    cycles(2); start = 1'b1; align = 1'b1;
    cycles(1); start = 1'b0; align = 1'b0;
    cycles(30);
    exp_q.push_back(16'd8); exp_q.push_back(16'd8);
    check_gaps("burst");
    check("burst high cycles", hi_cnt, 12);
    check("burst busy after", int'(busy_o), 0);

    // start with a zero count, and align while idle: nothing happens.
    clear_log();
    bc = 8'd0; start = 1'b1;
    cycles(1); start = 1'b0; align = 1'b1;
    cycles(1); align = 1'b0;
    cycles(10);
    check("zero burst edges", edge_t.size(), 0);
    check("zero burst busy", int'(busy_o), 0);
    mode = 2'd0;

    // Stop at high count 1 with H=8: full 8-cycle high, then idle.
    clear_log();
    half = 8'd8; mode = 2'd1;
    cycles(2); mode = 2'd0;
    wait_idle("drain");
    check("drain high cycles", hi_cnt, 8);
    check("drain edges", edge_t.size(), 1);

    // Stop during the low phase: immediate idle, no further rise.
    clear_log();
    mode = 2'd1;
    cycles(11); mode = 2'd0;
    @(posedge aclk); #2;
    check("low stop busy", int'(busy_o), 0);
    cycles(20);
    check("low stop high cycles", hi_cnt, 8);
    check("low stop edges", edge_t.size(), 1);

    // Align at high count 2 (H=6), then align together with stop.
    clear_log();
    half = 8'd6; mode = 2'd1;
    cycles(3); align = 1'b1;
    cycles(1); align = 1'b0;
    cycles(8); align = 1'b1; mode = 2'd0;
    cycles(1); align = 1'b0;
    wait_idle("align");
    exp_q.push_back(16'd9);
    check_gaps("align");
    check("align high cycles", hi_cnt, 9);

    // Reset asserted mid-burst clears outputs without waiting for a clock.
    half = 8'd4; bc = 8'd3; mode = 2'd2; start = 1'b1;
    cycles(1); start = 1'b0;
    cycles(4);
    #2 aclk_rst = 1'b1;
    #1;
    check("async rst sysref", int'(sysref_o), 0);
    check("async rst edge", int'(edge_o), 0);
    check("async rst busy", int'(busy_o), 0);
    mode = 2'd0;
    cycles(2);
    aclk_rst = 1'b0;
    clear_log();
    cycles(10);
    check("post rst edges", edge_t.size(), 0);
    check("post rst state", int'(dbg_state), int'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
